// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types for the data-memory Avalon bridge.
// Holds the bridge FSM state and the read data returned on a timeout.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    DONE
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_avalon_bridge_if.sv
// dmem_avalon_bridge_if: Avalon-MM master bundle for the dmem bridge.
// master: bridge drives command, slave: fabric drives wait/data.
interface dmem_avalon_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdatavalid,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdatavalid,
    output avm_readdata
  );
endinterface

// File: rtl/dmem_avalon_bridge_timeout_counter.sv
// bridge_timeout_counter: cycle counter, clear/enable, expire at
// TIMEOUT_CYCLES-1 counted cycles. Ports: clk, clear, enable, expire.
module bridge_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (enable && count != LAST)
      count <= count + 1'b1;
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/dmem_avalon_bridge.sv
// dmem_avalon_bridge: core dmem strobes -> Avalon-MM, with stall, timeout,
// sticky errors and rd/wr counters. Ports: clk, reset, core_*, bus, err_*, counts.
module dmem_avalon_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_writedata,
  input  logic [DATA_W/8-1:0] core_byteenable,
  input  logic                core_read_en,
  input  logic                core_write_en,
  output logic [DATA_W-1:0]   core_readdata,
  output logic                core_stall,
  dmem_avalon_bridge_if.master bus,
  input  logic                err_clear,
  output logic                err_timeout,
  output logic                err_both,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);
  localparam int BE_W = DATA_W / 8;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              is_wr_q, is_wr_d;
  logic              tmo_q, tmo_d;
  logic              eto_q, eto_d;
  logic              eboth_q, eboth_d;
  logic [31:0]       rdc_q, rdc_d;
  logic [31:0]       wrc_q, wrc_d;

  logic req, busy, expire, set_to, set_both;

  assign req  = core_read_en | core_write_en;
  assign busy = (state_q == CMD) || (state_q == RDATA);

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .clear  (reset | ~busy),
    .enable (busy),
    .expire (expire)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state; timeout beats a same-cycle accept or data beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = CMD;
      CMD: begin
        if (expire)
          state_d = DONE;
        else if (!bus.avm_waitrequest)
          state_d = (is_wr_q || bus.avm_readdatavalid) ? DONE : RDATA;
      end
      RDATA: if (expire || bus.avm_readdatavalid) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  assign set_both = (state_q == IDLE) && core_read_en && core_write_en;
  assign set_to   = busy && expire;

  // datapath / output next values
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    read_d  = read_q;
    write_d = write_q;
    is_wr_d = is_wr_q;
    tmo_d   = tmo_q;
    rdc_d   = rdc_q;
    wrc_d   = wrc_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = core_addr;
          wdata_d = core_writedata;
          be_d    = core_byteenable;
          write_d = core_write_en;
          read_d  = ~core_write_en;
          is_wr_d = core_write_en;
          tmo_d   = 1'b0;
        end
      end
      CMD: begin
        if (expire) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          tmo_d   = 1'b1;
          if (!is_wr_q) rdata_d = DATA_W'(TIMEOUT_DATA);
        end else if (!bus.avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (!is_wr_q && bus.avm_readdatavalid)
            rdata_d = bus.avm_readdata;
        end
      end
      RDATA: begin
        if (expire) begin
          tmo_d   = 1'b1;
          rdata_d = DATA_W'(TIMEOUT_DATA);
        end else if (bus.avm_readdatavalid) begin
          rdata_d = bus.avm_readdata;
        end
      end
      DONE: begin
        if (!tmo_q) begin
          if (is_wr_q) wrc_d = wrc_q + 32'd1;
          else         rdc_d = rdc_q + 32'd1;
        end
      end
    endcase
    eto_d   = err_clear ? 1'b0 : (eto_q | set_to);
    eboth_d = err_clear ? 1'b0 : (eboth_q | set_both);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      is_wr_q <= 1'b0;
      tmo_q   <= 1'b0;
      eto_q   <= 1'b0;
      eboth_q <= 1'b0;
      rdc_q   <= '0;
      wrc_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      is_wr_q <= is_wr_d;
      tmo_q   <= tmo_d;
      eto_q   <= eto_d;
      eboth_q <= eboth_d;
      rdc_q   <= rdc_d;
      wrc_q   <= wrc_d;
    end
  end

  assign core_stall         = (state_q != DONE) && req;
  assign core_readdata      = rdata_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = be_q;
  assign err_timeout        = eto_q;
  assign err_both           = eboth_q;
  assign rd_count           = rdc_q;
  assign wr_count           = wrc_q;

endmodule

// File: tb/tb_dmem_avalon_bridge.sv
// tb_dmem_avalon_bridge: transaction-level model of the dmem bridge,
// per-cycle compare of all outputs, directed pins plus random traffic.
module tb_dmem_avalon_bridge;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_addr;
  logic [31:0] core_writedata;
  logic [3:0]  core_byteenable;
  logic        core_read_en;
  logic        core_write_en;
  logic [31:0] core_readdata;
  logic        core_stall;
  logic        err_clear;
  logic        err_timeout;
  logic        err_both;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  dmem_avalon_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_avalon_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_addr       (core_addr),
    .core_writedata  (core_writedata),
    .core_byteenable (core_byteenable),
    .core_read_en    (core_read_en),
    .core_write_en   (core_write_en),
    .core_readdata   (core_readdata),
    .core_stall      (core_stall),
    .bus             (bus),
    .err_clear       (err_clear),
    .err_timeout     (err_timeout),
    .err_both        (err_both),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model of what every output must be in the current cycle
  bit          exp_valid = 0;
  bit          rand_clr  = 0;
  logic        exp_stall, exp_rd, exp_wr, exp_eto, exp_eboth;
  logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_rdc, exp_wrc;
  logic [3:0]  exp_be;
  int          stall_seen, wr_seen, rd_seen;

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      cmp("core_stall", 32'(core_stall), 32'(exp_stall));
      cmp("avm_read", 32'(bus.avm_read), 32'(exp_rd));
      cmp("avm_write", 32'(bus.avm_write), 32'(exp_wr));
      cmp("avm_address", bus.avm_address, exp_addr);
      cmp("avm_writedata", bus.avm_writedata, exp_wdata);
      cmp("avm_byteenable", 32'(bus.avm_byteenable), 32'(exp_be));
      cmp("core_readdata", core_readdata, exp_rdata);
      cmp("rd_count", rd_count, exp_rdc);
      cmp("wr_count", wr_count, exp_wrc);
      cmp("err_timeout", 32'(err_timeout), 32'(exp_eto));
      cmp("err_both", 32'(err_both), 32'(exp_eboth));
      if (core_stall) stall_seen++;
      if (bus.avm_write) wr_seen++;
      if (bus.avm_read) rd_seen++;
    end
  end

  // one cycle: compare at negedge, apply flag rules at the edge
  task automatic step(input bit sb, input bit st);
    @(negedge clk);
    @(posedge clk);
    if (err_clear) begin
      exp_eto   = 1'b0;
      exp_eboth = 1'b0;
    end else begin
      exp_eto   = exp_eto | st;
      exp_eboth = exp_eboth | sb;
    end
    #1;
    err_clear = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic noise();
    bus.avm_waitrequest   = 1'($urandom);
    bus.avm_readdatavalid = ($urandom_range(0, 3) == 0);
    bus.avm_readdata      = $urandom;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      core_read_en    = 1'b0;
      core_write_en   = 1'b0;
      core_addr       = $urandom;
      core_writedata  = $urandom;
      core_byteenable = 4'($urandom);
      noise();
      exp_stall = 1'b0;
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
      step(1'b0, 1'b0);
    end
  endtask

  // w: waitrequest cycles before accept; d: readdatavalid delay after accept
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         input int w, input int d, input logic [31:0] rdd);
    bit is_w;
    bit tmo;
    int kc;
    int kend;
    is_w = wr;
    kc   = is_w ? w : w + d;
    tmo  = (kc >= T - 1);
    kend = tmo ? T - 1 : kc;
    core_read_en    = rd;
    core_write_en   = wr;
    core_addr       = a;
    core_writedata  = wd;
    core_byteenable = b;
    noise();
    exp_stall = 1'b1;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    step(rd && wr, 1'b0);
    exp_addr  = a;
    exp_wdata = wd;
    exp_be    = b;
    for (int k = 0; k <= kend; k++) begin
      bus.avm_waitrequest   = (k < w);
      bus.avm_readdatavalid = !is_w && (k == w + d);
      bus.avm_readdata      = bus.avm_readdatavalid ? rdd : $urandom;
      exp_stall = 1'b1;
      exp_wr    = is_w;
      exp_rd    = !is_w && (k <= w);
      step(1'b0, tmo && (k == kend));
    end
    if (!is_w) exp_rdata = tmo ? 32'hDEADBEEF : rdd;
    exp_stall = 1'b0;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    noise();
    step(1'b0, 1'b0);
    if (!tmo) begin
      if (is_w) exp_wrc = exp_wrc + 1;
      else      exp_rdc = exp_rdc + 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    err_clear = 1'b0;
    core_read_en = 1'b0;
    core_write_en = 1'b0;
    core_addr = '0;
    core_writedata = '0;
    core_byteenable = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp("rst_read", 32'(bus.avm_read), 32'd0);
    cmp("rst_write", 32'(bus.avm_write), 32'd0);
    cmp("rst_addr", bus.avm_address, 32'd0);
    cmp("rst_rdata", core_readdata, 32'd0);
    cmp("rst_counts", rd_count | wr_count, 32'd0);
    cmp("rst_errs", 32'({err_timeout, err_both}), 32'd0);
    cmp("rst_stall", 32'(core_stall), 32'd0);
    exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_eto = 0; exp_eboth = 0;
    exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_rdata = 0;
    exp_rdc = 0; exp_wrc = 0;
    @(posedge clk);
    #1 exp_valid = 1;

    stall_seen = 0; wr_seen = 0;
    run_txn(0, 1, 32'h100, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    cmp("wr_stall_cycles", stall_seen, 2);
    cmp("wr_high_cycles", wr_seen, 1);
    cmp("wr_count_pin", wr_count, 1);
    gap(1);

    stall_seen = 0;
    run_txn(1, 0, 32'h200, 32'h0, 4'hF, 3, 2, 32'h12345678);
    cmp("rd_data_pin", core_readdata, 32'h12345678);
    cmp("rd_count_pin", rd_count, 1);
    cmp("rd_stall_cycles", stall_seen, 7);
    gap(1);

    stall_seen = 0;
    run_txn(1, 0, 32'h204, 32'h0, 4'h3, 0, 0, 32'hA5A55A5A);
    cmp("rd_fast_stall", stall_seen, 2);
    cmp("rd_fast_data", core_readdata, 32'hA5A55A5A);
    gap(1);

    stall_seen = 0; rd_seen = 0;
    run_txn(1, 0, 32'h208, 32'h0, 4'hF, 20, 0, 32'h0);
    cmp("tmo_stall", stall_seen, 9);
    cmp("tmo_read_cycles", rd_seen, 8);
    cmp("tmo_data", core_readdata, 32'hDEADBEEF);
    cmp("tmo_flag", 32'(err_timeout), 32'd1);
    cmp("tmo_rd_count", rd_count, 2);
    err_clear = 1'b1;
    gap(1);
    cmp("tmo_cleared", 32'(err_timeout), 32'd0);

    rd_seen = 0; wr_seen = 0;
    run_txn(1, 1, 32'h300, 32'h11223344, 4'hC, 1, 0, 32'h0);
    cmp("both_rd_cycles", rd_seen, 0);
    cmp("both_wr_cycles", wr_seen, 2);
    cmp("both_flag", 32'(err_both), 32'd1);
    cmp("both_wr_count", wr_count, 2);
    gap(2);

    rand_clr = 1;
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      run_txn(sel < 6, sel == 0 || sel >= 6, $urandom, $urandom,
              4'($urandom), $urandom_range(0, 9), $urandom_range(0, 4),
              $urandom);
      gap($urandom_range(0, 2));
    end
    rand_clr = 0;
    err_clear = 1'b0;
    gap(1);

    // reset while waiting for read data
    exp_valid = 0;
    core_read_en = 1'b1;
    core_write_en = 1'b0;
    core_addr = 32'h400;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    cmp("rdata_state_stall", 32'(core_stall), 32'd1);
    cmp("rdata_state_read", 32'(bus.avm_read), 32'd0);
    @(posedge clk);
    #1;
    cmp("post_rst_stall_en", 32'(core_stall), 32'd1);
    cmp("post_rst_read", 32'(bus.avm_read), 32'd0);
    reset = 1'b0;
    core_read_en = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 32'hAAAA5555;
    #1;
    cmp("post_rst_stall_off", 32'(core_stall), 32'd0);
    @(posedge clk);
    #1 bus.avm_readdatavalid = 1'b0;
    cmp("stale_rdv_data", core_readdata, 32'd0);
    cmp("stale_rdv_count", rd_count, 32'd0);
    cmp("stale_rdv_read", 32'(bus.avm_read), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
